// File: rtl/reg_file_scrub.sv
// reg_file_scrub: parametrised 2-read / 1-write register file with a
// range-clear engine that fills an inclusive, wrap-around address range
// with a programmable value, one word per clock.
// Optional feature macro: REG_FILE_SCRUB_AUTO_CLEAR_EN -- when defined, reset
// launches a full zero-fill of the array instead of returning to IDLE.
module reg_file_scrub #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [ADDR_W-1:0] clr_lo,
  input  logic [ADDR_W-1:0] clr_hi,
  input  logic [DATA_W-1:0] fill_val,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] rd_addr0,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [DATA_W-1:0] rd_data0,
  output logic [DATA_W-1:0] rd_data1,
  output logic              busy,
  output logic              done
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]   end_q, end_d;
  logic [DATA_W-1:0]   fill_q, fill_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  // State register; reset either parks the engine or arms a full zero-fill
  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef REG_FILE_SCRUB_AUTO_CLEAR_EN
      state_q <= CLEAR;
      ptr_q   <= '0;
      end_q   <= ADDR_W'(DEPTH - 1);
      fill_q  <= '0;
`else
      state_q <= IDLE;
      ptr_q   <= '0;
      end_q   <= '0;
      fill_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      end_q   <= end_d;
      fill_q  <= fill_d;
    end
  end

  // Storage array; no reset so contents survive rst, and rst blocks any write
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Next-state and write-port arbitration: engine owns the port during CLEAR
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    end_d     = end_q;
    fill_d    = fill_q;
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    case (state_q)
      IDLE: begin
        mem_we = wr_en;
        if (go) begin
          ptr_d   = clr_lo;
          end_d   = clr_hi;
          fill_d  = fill_val;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = fill_q;
        if (ptr_q == end_q) begin
          state_d = DONE;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      DONE: begin
        mem_we  = wr_en;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake outputs decoded purely from the registered state
  always_comb begin
    busy     = (state_q == CLEAR);
    done     = (state_q == DONE);
    wr_ready = ~busy;
  end

  assign rd_data0 = mem_q[rd_addr0];
  assign rd_data1 = mem_q[rd_addr1];

endmodule

// File: tb/tb_reg_file_scrub.sv
// Testbench for reg_file_scrub: directed scenarios followed by random traffic,
// all checked against a queue-based reference model of the clear engine.
module tb_reg_file_scrub;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          go;
  logic [AW-1:0] clr_lo, clr_hi;
  logic [DW-1:0] fill_val;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic [AW-1:0] rd_addr0, rd_addr1;
  logic [DW-1:0] rd_data0, rd_data1;
  logic          busy;
  logic          done;

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model: array contents, queue of addresses still to be filled,
  // the fill value for that queue and a pending done pulse.
  logic [DW-1:0] modelMem [DEPTH];
  int            pendAddr [$];
  logic [DW-1:0] pendFill;
  bit            modelDone;

  reg_file_scrub #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .go       (go),
    .clr_lo   (clr_lo),
    .clr_hi   (clr_hi),
    .fill_val (fill_val),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .rd_addr0 (rd_addr0),
    .rd_addr1 (rd_addr1),
    .rd_data0 (rd_data0),
    .rd_data1 (rd_data1),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock edge of the model, using the inputs sampled at that edge
  task automatic modelStep(input bit r, input bit g, input int lo, input int hi,
                           input logic [DW-1:0] fv, input bit we, input int wa,
                           input logic [DW-1:0] wd);
    int n;
    if (r) begin
      pendAddr.delete();
      modelDone = 0;
`ifdef REG_FILE_SCRUB_AUTO_CLEAR_EN
      for (int i = 0; i < DEPTH; i++) pendAddr.push_back(i);
      pendFill = '0;
`endif
    end else if (pendAddr.size() > 0) begin
      modelMem[pendAddr.pop_front()] = pendFill;
      if (pendAddr.size() == 0) modelDone = 1;
    end else begin
      if (we) modelMem[wa] = wd;
      if (modelDone) begin
        modelDone = 0;
      end else if (g) begin
        n = ((hi - lo + DEPTH) % DEPTH) + 1;
        for (int i = 0; i < n; i++) pendAddr.push_back((lo + i) % DEPTH);
        pendFill = fv;
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    bit expBusy;
    expBusy = (pendAddr.size() > 0);
    check({tag, ".busy"}, DW'(busy), DW'(expBusy));
    check({tag, ".done"}, DW'(done), DW'(modelDone));
    check({tag, ".wr_ready"}, DW'(wr_ready), DW'(!expBusy));
    if (!$isunknown(modelMem[rd_addr0])) check({tag, ".rd0"}, rd_data0, modelMem[rd_addr0]);
    if (!$isunknown(modelMem[rd_addr1])) check({tag, ".rd1"}, rd_data1, modelMem[rd_addr1]);
  endtask

  // Drive one cycle of inputs, advance DUT and model together, then compare
  task automatic applyStimulus(input string tag, input bit r, input bit g,
                               input int lo, input int hi, input logic [DW-1:0] fv,
                               input bit we, input int wa, input logic [DW-1:0] wd,
                               input int ra0, input int ra1);
    rst = r; go = g; clr_lo = AW'(lo); clr_hi = AW'(hi); fill_val = fv;
    wr_en = we; wr_addr = AW'(wa); wr_data = wd;
    rd_addr0 = AW'(ra0); rd_addr1 = AW'(ra1);
    @(posedge clk);
    modelStep(r, g, lo, hi, fv, we, wa, wd);
    #1;
    checkOutput(tag);
  endtask

  task automatic idleSteps(input string tag, input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(tag, 0, 0, 0, 0, '0, 0, 0, '0, $urandom_range(0, DEPTH-1), $urandom_range(0, DEPTH-1));
  endtask

  task automatic sweepArray(input string tag);
    for (int i = 0; i < DEPTH/2; i++)
      applyStimulus(tag, 0, 0, 0, 0, '0, 0, 0, '0, i, i + DEPTH/2);
  endtask

  task automatic waitIdle(input string tag);
    for (int i = 0; i < 40 && (pendAddr.size() > 0 || modelDone); i++) idleSteps(tag, 1);
  endtask

  task automatic preload(input string tag, input bit indexed, input logic [DW-1:0] v);
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(tag, 0, 0, 0, 0, '0, 1, i, indexed ? DW'(i + 1) : v, i, (i + 3) % DEPTH);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) modelMem[i] = 'x;
    pendFill  = '0;
    modelDone = 0;

    // Reset state
    applyStimulus("reset", 1, 0, 0, 0, '0, 0, 0, '0, 0, 1);
    waitIdle("reset_fill");

    // Full fill of the whole array with zero
    preload("full_pre", 0, 32'hDEADBEEF);
    applyStimulus("full_go", 0, 1, 0, 15, 32'h0, 0, 0, '0, 0, 15);
    idleSteps("full_run", 17);
    sweepArray("full_sweep");

    // Wrap-around range 14..1
    preload("wrap_pre", 1, '0);
    applyStimulus("wrap_go", 0, 1, 14, 1, 32'hA5A5A5A5, 0, 0, '0, 14, 2);
    idleSteps("wrap_run", 6);
    sweepArray("wrap_sweep");

    // Writes dropped and go ignored while clearing, write accepted afterwards
    applyStimulus("drop_go", 0, 1, 0, 7, 32'h55, 0, 0, '0, 3, 8);
    idleSteps("drop_run", 2);
    applyStimulus("drop_wr", 0, 1, 8, 9, 32'h99, 1, 3, 32'h1234, 3, 8);
    idleSteps("drop_run2", 7);
    sweepArray("drop_sweep");
    applyStimulus("late_wr", 0, 0, 0, 0, '0, 1, 3, 32'h1234, 3, 9);
    idleSteps("late_chk", 1);

    // Simultaneous go and user write on the same IDLE edge
    applyStimulus("sim_go", 0, 1, 5, 5, 32'h0, 1, 5, 32'h77, 5, 4);
    applyStimulus("sim_run", 0, 0, 0, 0, '0, 0, 0, '0, 5, 4);
    applyStimulus("sim_idle", 0, 0, 0, 0, '0, 0, 0, '0, 5, 4);

    // Reset on the 4th clear edge
    preload("rst_pre", 0, 32'hFF);
    applyStimulus("rst_go", 0, 1, 0, 15, 32'h11, 0, 0, '0, 0, 3);
    idleSteps("rst_run", 3);
    applyStimulus("rst_mid", 1, 0, 0, 0, '0, 1, 7, 32'hBAD, 2, 3);
    waitIdle("rst_fill");
    sweepArray("rst_sweep");

    // Dual read of distinct words in one cycle
    applyStimulus("dual_w2", 0, 0, 0, 0, '0, 1, 2, 32'h2222, 2, 9);
    applyStimulus("dual_w9", 0, 0, 0, 0, '0, 1, 9, 32'h9999, 2, 9);
    applyStimulus("dual_rd", 0, 0, 0, 0, '0, 0, 0, '0, 2, 9);

    // Random traffic
    for (int i = 0; i < 400; i++)
      applyStimulus("rand", ($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0),
                    $urandom_range(0, DEPTH-1), $urandom_range(0, DEPTH-1), $urandom(),
                    $urandom_range(0, 1), $urandom_range(0, DEPTH-1), $urandom(),
                    $urandom_range(0, DEPTH-1), $urandom_range(0, DEPTH-1));
    waitIdle("rand_end");
    sweepArray("rand_sweep");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
